pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Memory-mapped two-channel PWM input-capture peripheral; the measuring counterpart of the timer's PWM generator.
- Measures high time and period of two external pulse inputs in prescaled clock ticks.
- Sits on the same chip-select/read/write register bus as the timer; results are read back by the core.
- Can be looped back from timer pwm outputs for self-test.

Parameters:
- CNT_WIDTH, 32, width of measurement counters and result registers (2..32); results zero-extended to 32 bits on readData.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 freezes capture FSMs, counters and prescaler; bus access still works.
- chipSelect  in  1  block selected.
- write  in  1  register write strobe, qualified by chipSelect.
- read  in  1  register read strobe, qualified by chipSelect.
- addr  in  5  register word address.
- writeData  in  32  write data.
- pwm1in  in  1  channel 1 pulse input, asynchronous.
- pwm2in  in  1  channel 2 pulse input, asynchronous.
- readData  out  32  read data.
- irq  out  1  interrupt request.

Behaviour:
- Register map (others read 0, writes ignored):
  - 0 CTRL rw: bit0 ch1 enable, bit1 ch2 enable, bit2 irq enable.
  - 1 PRESC rw: prescaler value P, 32 bit.
  - 2 STATUS: bit0 v1, bit1 v2, bit2 ovf1, bit3 ovf2; write-1-to-clear.
  - 3 PERIOD1 ro. 4 HIGH1 ro. 5 PERIOD2 ro. 6 HIGH2 ro.
- Reset: all registers, FSMs, counters, synchronizers = 0; readData = 0; irq = 0.
- Writes commit on the clock edge where chipSelect&write are high.
- readData is combinational: the register at addr when chipSelect&read, else 0.
- Input path, per channel:
  - 2-flop synchronizer, then a previous-value flop.
  - Rise/fall edge flagged 3 cycles after the pin changes.
  - Synchronizer and edge flops always run, even when en=0, so edges occurring while en=0 are lost.
- Prescaler, per channel:
  - pcnt increments every enabled cycle.
  - Tick when pcnt>=P, with pcnt<=0 on tick.
  - On any edge event: pcnt<=0.
  - A new P takes effect the next cycle.
- Counter rule: the edge cycle loads cnt<=1; each later tick increments cnt. A level lasting N clocks yields ceil(N/(P+1)).
- FSM per channel (advances only when en=1 and channel enabled):
  - IDLE: on rise -> cnt<=1, go HIGH.
  - HIGH: on fall -> shadow<=cnt, cnt<=1, go LOW.
  - LOW: on rise -> PERIODx<=shadow+cnt, HIGHx<=shadow, vx<=1, cnt<=1, go HIGH.
  - PERIODx and HIGHx always update together, so they are coherent.
- Overflow: a tick with cnt at 2^CNT_WIDTH-1 (or shadow+cnt exceeding it) sets ovfx, FSM goes to IDLE, and result registers hold.
- Channel enable cleared: FSM goes to IDLE and cnt clears next cycle; result registers and flags hold.
- Simultaneous hardware set and write-1-clear of a flag: set wins.
- Reset mid-measurement: everything returns to the reset state; the next measurement starts from IDLE.
- irq = CTRL.bit2 & (|STATUS[3:0]), registered, one cycle after the flag or CTRL change.
- Pulse narrower than 3 clocks may be missed; this is not flagged.

Test Plan:
- Reset, then read all addresses 0..31 -> every readData = 0, irq = 0.
- CTRL=1, P=0, pwm1in high 4 / low 6 clocks repeating -> after 2nd rising edge HIGH1=4, PERIOD1=10, v1=1; PERIOD2/HIGH2 remain 0.
- P=1, pwm2in high 10 / low 10, CTRL=2 -> HIGH2=5, PERIOD2=10; write STATUS=2 -> v2 cleared; v2 sets again one period later.
- CTRL=5, pwm1in 3/5 -> irq rises one cycle after v1; write STATUS=1 in the same cycle as the next latch -> v1 stays 1.
- CNT_WIDTH=8, P=0, pwm1in held high 300 clocks -> ovf1=1 at the 255th tick, FSM IDLE, HIGH1/PERIOD1 unchanged; next full 4/6 cycle measures correctly.
- Mid-HIGH, drop en for 20 clocks, or clear CTRL bit0, or pulse rst -> no latch from the broken cycle; for rst, all registers read 0; recapture is correct after resume.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: two-channel PWM high-time/period capture; ports clk, rst, en, chipSelect/write/read/addr/writeData/readData register bus, pwm1in/pwm2in async pulse inputs, irq
module pwm_capture #(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        chipSelect,
  input  logic        write,
  input  logic        read,
  input  logic [4:0]  addr,
  input  logic [31:0] writeData,
  input  logic        pwm1in,
  input  logic        pwm2in,
  output logic [31:0] readData,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic [2:0] ctrl;
  logic [31:0] presc;
  logic [3:0] status;
  logic [1:0] set_v, set_ovf, pins;
  logic wr;
  assign pins = {pwm2in, pwm1in};
  assign wr = chipSelect & write;
  for (genvar c = 0; c < 2; c++) begin : g
    logic [2:0] sy;
    logic [31:0] pcnt;
    logic [CNT_WIDTH-1:0] cnt, shadow, per, hgt;
    logic [CNT_WIDTH:0] sum;
    state_t st;
    logic rise, fall, tick, run, sat;
    assign rise = sy[1] & ~sy[2];
    assign fall = ~sy[1] & sy[2];
    assign tick = pcnt >= presc;
    assign run = en & ctrl[c];
    assign sum = {1'b0, shadow} + {1'b0, cnt};
    assign sat = tick & (cnt == MAX) & ~rise & ~fall & (st != IDLE);
    assign set_v[c] = run & (st == LOW) & rise & ~sum[CNT_WIDTH];
    assign set_ovf[c] = run & (sat | ((st == LOW) & rise & sum[CNT_WIDTH]));
    always_ff @(posedge clk) begin
      if (rst) begin
        sy <= '0;
        pcnt <= '0;
        cnt <= '0;
        shadow <= '0;
        per <= '0;
        hgt <= '0;
        st <= IDLE;
      end else begin
        sy <= {sy[1:0], pins[c]};
        if (en) pcnt <= (rise | fall | tick) ? '0 : pcnt + 32'd1;
        if (!ctrl[c]) begin
          st <= IDLE;
          cnt <= '0;
        end else if (en) begin
          case (st)
            IDLE: if (rise) begin
              cnt <= ONE;
              st <= HIGH;
            end
            HIGH: if (fall) begin
              shadow <= cnt;
              cnt <= ONE;
              st <= LOW;
            end else if (rise) cnt <= ONE;
            else if (sat) st <= IDLE;
            else if (tick) cnt <= cnt + ONE;
            LOW: if (rise && sum[CNT_WIDTH]) st <= IDLE;
            else if (rise) begin
              per <= sum[CNT_WIDTH-1:0];
              hgt <= shadow;
              cnt <= ONE;
              st <= HIGH;
            end else if (fall || sat) st <= IDLE;
            else if (tick) cnt <= cnt + ONE;
            default: st <= IDLE;
          endcase
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      presc <= '0;
      status <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && addr == 5'd0) ctrl <= writeData[2:0];
      if (wr && addr == 5'd1) presc <= writeData;
      status <= (status & ~((wr && addr == 5'd2) ? writeData[3:0] : 4'd0)) | {set_ovf, set_v};
      irq <= ctrl[2] & (|status);
    end
  end
  always_comb begin
    readData = '0;
    if (chipSelect && read)
      readData = addr == 5'd0 ? {29'd0, ctrl} :
                 addr == 5'd1 ? presc :
                 addr == 5'd2 ? {28'd0, status} :
                 addr == 5'd3 ? 32'(g[0].per) :
                 addr == 5'd4 ? 32'(g[0].hgt) :
                 addr == 5'd5 ? 32'(g[1].per) :
                 addr == 5'd6 ? 32'(g[1].hgt) : 32'd0;
  end
endmodule
